// File: rtl/axil_write_responder_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) between a master and the responder.
interface axil_write_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] s_awaddr;
  logic                  s_awvalid;
  logic                  s_awready;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic [STRB_WIDTH-1:0] s_wstrb;
  logic                  s_wvalid;
  logic                  s_wready;
  logic [1:0]            s_bresp;
  logic                  s_bvalid;
  logic                  s_bready;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_awready, s_wready, s_bresp, s_bvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_awready, s_wready, s_bresp, s_bvalid
  );
endinterface

// File: rtl/axil_write_responder.sv
// AXI4-Lite write endpoint: collects AW and W in any order, issues one register
// write strobe, then returns OKAY/SLVERR on B. One transaction in flight.
module axil_write_responder #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned IDX_WIDTH  = $clog2(NUM_REGS)
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  axil_write_responder_if.slave   s,
  output logic                    reg_wr_en,
  output logic [IDX_WIDTH-1:0]    reg_wr_idx,
  output logic [DATA_WIDTH-1:0]   reg_wr_data,
  output logic [DATA_WIDTH/8-1:0] reg_wr_strb,
  input  logic                    reg_wr_err
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {COLLECT, WRITE, RESP} state_t;

  state_t                state;
  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  aw_held_n;
  logic                  w_held_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic [STRB_WIDTH-1:0] strb_n;
  logic                  in_range_n;

  // Handshake detection and the address/data seen once this edge's handshakes land.
  always_comb begin
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    aw_held_n  = aw_held;
    w_held_n   = w_held;
    addr_n     = aw_addr_q;
    data_n     = w_data_q;
    strb_n     = w_strb_q;
    in_range_n = 1'b0;
    if (state == COLLECT) begin
      aw_hs = s.s_awvalid && s.s_awready;
      w_hs  = s.s_wvalid && s.s_wready;
    end
    aw_held_n = aw_held || aw_hs;
    w_held_n  = w_held || w_hs;
    if (!aw_held) addr_n = s.s_awaddr;
    if (!w_held) begin
      data_n = s.s_wdata;
      strb_n = s.s_wstrb;
    end
    in_range_n = (addr_n < ADDR_LIMIT);
  end

  // Collect/write/respond sequencer with all bus and backend outputs registered.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= COLLECT;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      s.s_awready <= 1'b0;
      s.s_wready  <= 1'b0;
      s.s_bvalid  <= 1'b0;
      s.s_bresp   <= RESP_OKAY;
      reg_wr_en   <= 1'b0;
      reg_wr_idx  <= '0;
      reg_wr_data <= '0;
      reg_wr_strb <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= s.s_awaddr;
          end
          if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= s.s_wdata;
            w_strb_q <= s.s_wstrb;
          end
          s.s_awready <= !aw_held_n;
          s.s_wready  <= !w_held_n;
          if (aw_held_n && w_held_n) begin
            state       <= WRITE;
            reg_wr_en   <= in_range_n;
            reg_wr_idx  <= addr_n[IDX_WIDTH+1:2];
            reg_wr_data <= data_n;
            reg_wr_strb <= strb_n;
          end
        end
        WRITE: begin
          // reg_wr_en doubles as the in-range flag for this cycle.
          reg_wr_en  <= 1'b0;
          s.s_bvalid <= 1'b1;
          s.s_bresp  <= (reg_wr_en && !reg_wr_err) ? RESP_OKAY : RESP_SLVERR;
          state      <= RESP;
        end
        RESP: begin
          if (s.s_bready) begin
            s.s_bvalid <= 1'b0;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            state      <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_write_responder.sv
// Self-checking bench for axil_write_responder: directed table, corner sequences, random traffic.
module tb_axil_write_responder;
  localparam int unsigned NUM_REGS = 8;

  logic        aclk;
  logic        aresetn;
  logic        reg_wr_en;
  logic [2:0]  reg_wr_idx;
  logic [31:0] reg_wr_data;
  logic [3:0]  reg_wr_strb;
  logic        reg_wr_err;

  int n_vec;
  int n_err;

  axil_write_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s ();

  axil_write_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NUM_REGS)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s           (s),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_idx  (reg_wr_idx),
    .reg_wr_data (reg_wr_data),
    .reg_wr_strb (reg_wr_strb),
    .reg_wr_err  (reg_wr_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic        err;
    logic        exp_en;
    logic [2:0]  exp_idx;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    s.s_awvalid = 1'b0;
    s.s_wvalid  = 1'b0;
    s.s_bready  = 1'b0;
  endtask

  // Master-side transaction driver with a cycle-by-cycle timeline check.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly, input logic err,
                          input logic exp_en, input logic [2:0] exp_idx, input logic [1:0] exp_resp);
    int  c;
    int  hs;
    int  bcnt;
    bit  aw_done, w_done, b_done, aw_go, w_go, b_go;
    c = 0; hs = -1; bcnt = 0;
    aw_done = 0; w_done = 0; b_done = 0;
    s.s_awaddr = addr;
    s.s_wdata  = data;
    s.s_wstrb  = strb;
    while (!b_done && c < 60) begin
      s.s_awvalid = !aw_done && (c >= aw_dly);
      s.s_wvalid  = !w_done && (c >= w_dly);
      s.s_bready  = s.s_bvalid && (bcnt > b_dly);
      reg_wr_err  = reg_wr_en ? err : 1'($urandom);
      aw_go = s.s_awvalid && s.s_awready;
      w_go  = s.s_wvalid && s.s_wready;
      b_go  = s.s_bvalid && s.s_bready;
      step();
      c++;
      if (aw_go) begin aw_done = 1; s.s_awaddr = $urandom; end
      if (w_go) begin w_done = 1; s.s_wdata = $urandom; s.s_wstrb = 4'($urandom); end
      if (hs < 0 && aw_done && w_done) hs = c;
      if (b_go) b_done = 1;
      if (hs < 0) begin
        chk("awready_collect", 64'(s.s_awready), 64'(!aw_done));
        chk("wready_collect", 64'(s.s_wready), 64'(!w_done));
        chk("wr_en_idle", 64'(reg_wr_en), 64'(0));
        chk("bvalid_idle", 64'(s.s_bvalid), 64'(0));
      end else if (c == hs) begin
        chk("readies_write", 64'({s.s_awready, s.s_wready}), 64'(0));
        chk("wr_en", 64'(reg_wr_en), 64'(exp_en));
        if (exp_en) begin
          chk("wr_idx", 64'(reg_wr_idx), 64'(exp_idx));
          chk("wr_data", 64'(reg_wr_data), 64'(data));
          chk("wr_strb", 64'(reg_wr_strb), 64'(strb));
        end
        chk("bvalid_write", 64'(s.s_bvalid), 64'(0));
      end else if (!b_done) begin
        bcnt++;
        chk("readies_resp", 64'({s.s_awready, s.s_wready}), 64'(0));
        chk("wr_en_resp", 64'(reg_wr_en), 64'(0));
        chk("bvalid_resp", 64'(s.s_bvalid), 64'(1));
        chk("bresp", 64'(s.s_bresp), 64'(exp_resp));
      end else begin
        chk("bvalid_drop", 64'(s.s_bvalid), 64'(0));
        chk("readies_after_b", 64'({s.s_awready, s.s_wready}), 64'(0));
      end
    end
    if (!b_done) chk("b_timeout", 64'(0), 64'(1));
    idle_inputs();
    step();
    chk("readies_return", 64'({s.s_awready, s.s_wready}), 64'(2'b11));
  endtask

  initial begin
    logic [31:0] ra, rd;
    logic [3:0]  rs;
    logic        re, ren;
    n_vec = 0;
    n_err = 0;

    vecs[0] = '{32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b0, 1'b1, 3'd1, 2'b00};
    vecs[1] = '{32'h1C, 32'h12345678, 4'h3, 3, 0, 0, 1'b0, 1'b1, 3'd7, 2'b00};
    vecs[2] = '{32'h20, 32'hCAFEF00D, 4'hF, 0, 1, 0, 1'b0, 1'b0, 3'd0, 2'b10};
    vecs[3] = '{32'h08, 32'hA5A5A5A5, 4'hC, 0, 0, 5, 1'b1, 1'b1, 3'd2, 2'b10};
    vecs[4] = '{32'h10, 32'h0000FFFF, 4'h1, 0, 2, 1, 1'b0, 1'b1, 3'd4, 2'b00};
    vecs[5] = '{32'hFFFFFFFC, 32'h11111111, 4'hF, 1, 1, 0, 1'b0, 1'b0, 3'd0, 2'b10};
    vecs[6] = '{32'h1F, 32'h87654321, 4'h8, 2, 0, 2, 1'b0, 1'b1, 3'd7, 2'b00};
    vecs[7] = '{32'h03, 32'h5A5A5A5A, 4'h6, 0, 0, 0, 1'b1, 1'b1, 3'd0, 2'b10};

    s.s_awaddr = '0; s.s_wdata = '0; s.s_wstrb = '0;
    idle_inputs();
    reg_wr_err = 1'b0;
    aresetn = 1'b0;
    step();
    step();
    chk("rst_readies", 64'({s.s_awready, s.s_wready}), 64'(0));
    chk("rst_bvalid", 64'(s.s_bvalid), 64'(0));
    chk("rst_bresp", 64'(s.s_bresp), 64'(0));
    chk("rst_wr_en", 64'(reg_wr_en), 64'(0));
    chk("rst_wr_fields", 64'({reg_wr_idx, reg_wr_data, reg_wr_strb}), 64'(0));
    aresetn = 1'b1;
    #1;
    chk("readies_before_edge", 64'({s.s_awready, s.s_wready}), 64'(0));
    step();
    chk("readies_first_edge", 64'({s.s_awready, s.s_wready}), 64'(2'b11));

    for (int i = 0; i < 8; i++)
      do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly,
               vecs[i].b_dly, vecs[i].err, vecs[i].exp_en, vecs[i].exp_idx, vecs[i].exp_resp);

    // Next AW/W held valid through RESP: only accepted after the B handshake, in order.
    s.s_awaddr = 32'h04; s.s_wdata = 32'h1; s.s_wstrb = 4'hF;
    s.s_awvalid = 1'b1; s.s_wvalid = 1'b1; reg_wr_err = 1'b0;
    step();
    chk("seq_a_en", 64'({reg_wr_en, reg_wr_idx}), 64'({1'b1, 3'd1}));
    chk("seq_a_data", 64'(reg_wr_data), 64'(32'h1));
    s.s_awaddr = 32'h08; s.s_wdata = 32'h2;
    step();
    chk("seq_a_bvalid", 64'({s.s_bvalid, s.s_bresp}), 64'({1'b1, 2'b00}));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("seq_resp_hold", 64'({s.s_bvalid, s.s_awready, s.s_wready, reg_wr_en}), 64'(4'b1000));
    end
    s.s_bready = 1'b1;
    step();
    s.s_bready = 1'b0;
    chk("seq_a_bdone", 64'({s.s_bvalid, s.s_awready, s.s_wready, reg_wr_en}), 64'(0));
    step();
    chk("seq_reopen", 64'({s.s_awready, s.s_wready, reg_wr_en}), 64'(3'b110));
    step();
    s.s_awvalid = 1'b0; s.s_wvalid = 1'b0;
    chk("seq_b_en", 64'({reg_wr_en, reg_wr_idx}), 64'({1'b1, 3'd2}));
    chk("seq_b_data", 64'(reg_wr_data), 64'(32'h2));
    step();
    chk("seq_b_bvalid", 64'({s.s_bvalid, s.s_bresp}), 64'({1'b1, 2'b00}));
    s.s_bready = 1'b1;
    step();
    s.s_bready = 1'b0;
    step();
    chk("seq_b_readies", 64'({s.s_bvalid, s.s_awready, s.s_wready}), 64'(3'b011));

    // Reset while the write strobe is high: everything drops at once, nothing resumes.
    s.s_awaddr = 32'h0C; s.s_wdata = 32'hBADC0DE; s.s_wstrb = 4'hF;
    s.s_awvalid = 1'b1; s.s_wvalid = 1'b1;
    step();
    s.s_awvalid = 1'b0; s.s_wvalid = 1'b0;
    chk("mid_rst_pre_en", 64'(reg_wr_en), 64'(1));
    aresetn = 1'b0;
    #1;
    chk("mid_rst_async", 64'({reg_wr_en, s.s_awready, s.s_wready, s.s_bvalid}), 64'(0));
    step();
    chk("mid_rst_held", 64'({reg_wr_en, s.s_awready, s.s_wready, s.s_bvalid}), 64'(0));
    aresetn = 1'b1;
    s.s_bready = 1'b1;
    step();
    chk("mid_rst_release", 64'({s.s_awready, s.s_wready}), 64'(2'b11));
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_rst_quiet", 64'({s.s_bvalid, reg_wr_en}), 64'(0));
    end
    s.s_bready = 1'b0;

    // Random traffic against a plain address-decoding reference.
    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 47));
      rd = $urandom;
      rs = 4'($urandom);
      re = 1'($urandom);
      ren = (ra < NUM_REGS * 4);
      do_write(ra, rd, rs, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), re,
               ren, 3'((ra / 4) % NUM_REGS), (ren && !re) ? 2'b00 : 2'b10);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axil_write_responder.md
Name: axil_write_responder

Overview:
AXI4-Lite slave-side write channel endpoint that sits behind the interconnect's write-response router on each slave port. It accepts AW and W independently, performs one decoded register write to a local register bank, and generates the B response (OKAY/SLVERR) that the router returns to the master. It handles one outstanding write at a time.

Parameters:
ADDR_WIDTH, 32, width of s_awaddr
DATA_WIDTH, 32, data width; fixed at 32 (one word per register)
NUM_REGS, 8, number of 32-bit registers; valid byte addresses are 0 to NUM_REGS*4-1
IDX_WIDTH, $clog2(NUM_REGS), width of reg_wr_idx

Ports:
aclk  input  1  clock; all logic is on the rising edge
aresetn  input  1  asynchronous active-low reset
s_awaddr  input  ADDR_WIDTH  write address
s_awvalid  input  1  address valid
s_awready  output  1  address ready
s_wdata  input  DATA_WIDTH  write data
s_wstrb  input  DATA_WIDTH/8  byte strobes
s_wvalid  input  1  data valid
s_wready  output  1  data ready
s_bresp  output  2  write response; 2'b00 is OKAY, 2'b10 is SLVERR
s_bvalid  output  1  response valid
s_bready  input  1  response ready
reg_wr_en  output  1  one-cycle register write strobe
reg_wr_idx  output  IDX_WIDTH  register index, equal to awaddr[IDX_WIDTH+1:2]
reg_wr_data  output  DATA_WIDTH  write data
reg_wr_strb  output  DATA_WIDTH/8  byte enables
reg_wr_err  input  1  backend error, sampled while reg_wr_en=1

Behaviour:
- States: COLLECT, WRITE, RESP. Reset state is COLLECT.
- Reset values (applied asynchronously while aresetn=0):
  - s_awready=0, s_wready=0, s_bvalid=0, s_bresp=2'b00, reg_wr_en=0.
  - reg_wr_idx, reg_wr_data and reg_wr_strb = 0.
  - Both hold flags cleared.
- s_awready and s_wready are registered outputs. They rise on the first clock edge after aresetn deasserts.
- COLLECT:
  - s_awready=1 while no address is held; s_wready=1 while no data is held.
  - An AW handshake (awvalid&&awready) at edge N captures the address, sets the aw-hold flag and drops s_awready from N+1.
  - A W handshake does the same for data, strb and s_wready.
  - AW and W may arrive in either order, or both in the same cycle.
- Transition to WRITE: at the edge where both holds become set. The earliest case is both handshakes at the same edge N, giving WRITE during cycle N+1.
- WRITE (exactly one cycle):
  - Address in range (awaddr < NUM_REGS*4; bits [1:0] ignored): reg_wr_en=1 with registered idx, data and strb. bresp is taken as reg_wr_err ? SLVERR : OKAY, sampled in this cycle.
  - Address out of range: reg_wr_en stays 0 and bresp=SLVERR.
  - Next state is RESP.
- RESP:
  - s_bvalid=1, with s_bresp held stable until s_bready.
  - On the handshake edge: go to COLLECT, clear both holds and s_bvalid, and reassert s_awready/s_wready on the following cycle.
  - s_bready held high throughout gives a one-cycle bvalid pulse.
- Latency: reg_wr_en follows the later handshake by 1 cycle; s_bvalid follows it by 2 cycles.
- Ready gating:
  - s_awready and s_wready are 0 throughout WRITE and RESP, so there is no second transaction while one is pending.
  - The already-held side also stays 0 while waiting for the other side.
- Ignored inputs: s_awvalid/s_wvalid are ignored when the matching ready is 0. Held values are never overwritten.
- Reset mid-operation:
  - Any pending write or response is discarded; no bvalid and no reg_wr_en is issued afterwards.
  - reg_wr_en drops immediately (asynchronously) if it was asserted.

Test Plan:
- Simultaneous AW=0x04 and W=0xDEADBEEF (strb 4'hF) at edge N, bready=1, reg_wr_err=0 -> reg_wr_en=1 in cycle N+1 with idx=1 and data=0xDEADBEEF; bvalid=1 with bresp=00 in cycle N+2 for exactly one cycle; readies high again at N+4.
- W (0x12345678, strb 4'h3) at N, AW=0x1C at N+3 -> wready low from N+1 while awready stays 1; reg_wr_en at N+4 with idx=7 and strb=4'h3; bvalid at N+5.
- AW=0x20 (out of range, NUM_REGS=8) with valid W -> reg_wr_en never asserts; bvalid with bresp=2'b10.
- In-range write with reg_wr_err=1 during WRITE, bready held low for 5 cycles -> bvalid=1 and bresp=2'b10 stable for all 5 cycles; awready/wready stay 0 until after the handshake.
- Second AW presented while in RESP -> not accepted (awready=0); it is accepted only in the cycle after the B handshake, and the two writes complete in order.
- aresetn pulled low in the cycle reg_wr_en=1 -> reg_wr_en and all readies drop immediately; after release no bvalid appears; readies rise on the first edge after release.
